// File: rtl/perf_event_monitor.sv
// perf_event_monitor: saturating performance counters for the pipelined core.
// Counts commit and cache events while in RUN, freezes on a committed halt,
// and serves counter/status values through a registered select/read port.
//
// Read port: rd_en is a single-cycle request with no back-pressure. Each
// cycle with rd_en high captures the value selected by rd_sel, taken before
// that edge's counter update. The value appears on rd_data with rd_valid high
// for exactly one cycle at the next edge. rd_data holds its last value while
// rd_valid is low.
module perf_event_monitor #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             reg_write,
   input  logic             mem_write,
   input  logic             mem_read,
   input  logic             halt,
   input  logic             icache_req,
   input  logic             icache_hit,
   input  logic             dcache_req,
   input  logic             dcache_hit,
   input  logic             clear,
   input  logic             rd_en,
   input  logic [2:0]       rd_sel,
   output logic [CNT_W-1:0] rd_data,
   output logic             rd_valid,
   output logic             halted,
   output logic             hit_err
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   // Counter index map: 0 cycles, 1 inst, 2 loads, 3 icache_req,
   // 4 icache_hit, 5 dcache_req, 6 dcache_hit.
   localparam int NCNT = 7;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q [NCNT];
   logic [CNT_W-1:0] cnt_d [NCNT];
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic [NCNT-1:0]  inc;
   logic [CNT_W-1:0] status_word;
   logic [CNT_W-1:0] rd_mux;
   logic             err_evt;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic en);
      return (en && (v != CNT_MAX)) ? v + CNT_ONE : v;
   endfunction

   // Per-counter increment enables; an instruction counts at most once.
   always_comb begin
      inc[0]  = 1'b1;
      inc[1]  = halt | reg_write | mem_write;
      inc[2]  = mem_read;
      inc[3]  = icache_req;
      inc[4]  = icache_hit;
      inc[5]  = dcache_req;
      inc[6]  = dcache_hit;
      err_evt = (icache_hit & ~icache_req) | (dcache_hit & ~dcache_req);
   end

   // Read mux over the pre-update counter and status values.
   always_comb begin
      status_word    = '0;
      status_word[0] = (state_q == HALTED);
      status_word[1] = err_q;
      case (rd_sel)
         3'd0:    rd_mux = cnt_q[0];
         3'd1:    rd_mux = cnt_q[1];
         3'd2:    rd_mux = cnt_q[2];
         3'd3:    rd_mux = cnt_q[3];
         3'd4:    rd_mux = cnt_q[4];
         3'd5:    rd_mux = cnt_q[5];
         3'd6:    rd_mux = cnt_q[6];
         default: rd_mux = status_word;
      endcase
   end

   // Next-state logic: clear beats everything, HALTED freezes counting.
   always_comb begin
      state_d    = state_q;
      err_d      = err_q;
      rd_valid_d = rd_en;
      rd_data_d  = rd_en ? rd_mux : rd_data_q;
      for (int i = 0; i < NCNT; i++) cnt_d[i] = cnt_q[i];

      if (clear) begin
         state_d = RUN;
         err_d   = 1'b0;
         for (int i = 0; i < NCNT; i++) cnt_d[i] = '0;
      end else if (state_q == RUN) begin
         for (int i = 0; i < NCNT; i++) cnt_d[i] = sat_inc(cnt_q[i], inc[i]);
         if (err_evt) err_d = 1'b1;
         if (halt) state_d = HALTED;
      end
   end

   // State, counters and registered read port.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         err_q      <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         err_q      <= err_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign halted   = (state_q == HALTED);
   assign hit_err  = err_q;

endmodule
